// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the pipeline control slice.
// Holds the widths of the decoder control bundles and the bit positions
// inside each bundle, the ALUOp and forwarding-select codes, the bubble
// (all-zero) control bundle, and the forwarding-select helper.
package ctrl_pkg;

    localparam int unsigned WB_W  = 2;
    localparam int unsigned EX_W  = 4;
    localparam int unsigned MEM_W = 2;
    localparam int unsigned REG_W = 5;

    // wb = {RegWrite, MemtoReg}
    localparam int unsigned WB_REGWRITE = 1;
    localparam int unsigned WB_MEMTOREG = 0;

    // ex = {ALUSrc, ALUOp[1:0], RegDst}
    localparam int unsigned EX_ALUSRC   = 3;
    localparam int unsigned EX_ALUOP_HI = 2;
    localparam int unsigned EX_ALUOP_LO = 1;
    localparam int unsigned EX_REGDST   = 0;

    // mem = {MemRead, MemWrite}
    localparam int unsigned MEM_READ  = 1;
    localparam int unsigned MEM_WRITE = 0;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_e;

    typedef struct packed {
        logic [WB_W-1:0]  wb;
        logic [EX_W-1:0]  ex;
        logic [MEM_W-1:0] mem;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    // EX/MEM wins over MEM/WB because it holds the younger result.
    // Register 0 is hardwired, so a write to it never forwards.
    function automatic fwd_e fwd_sel(
        input logic             exmem_we,
        input logic [REG_W-1:0] exmem_dst,
        input logic             memwb_we,
        input logic [REG_W-1:0] memwb_dst,
        input logic [REG_W-1:0] src
    );
        fwd_e sel;
        sel = FWD_REG;
        if (exmem_we && (exmem_dst != '0) && (exmem_dst == src)) begin
            sel = FWD_EXMEM;
        end else if (memwb_we && (memwb_dst != '0) && (memwb_dst == src)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_pipe_hazard.sv
// hazard_detect: load-use hazard detection.
// Ports:
//   idex_memread_i  MemRead of the instruction currently in EX
//   idex_rt_i       rt (load destination) of the instruction in EX
//   id_rs_i/id_rt_i source registers of the instruction in ID
//   stall_o         load-use hazard present this cycle
//   pc_write_o      PC update enable (low while stalled)
//   ifid_write_o    IF/ID load enable (low while stalled)
//   flush_mux_o     1 = insert bubble into ID/EX
module hazard_detect
    import ctrl_pkg::*;
(
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    output logic             stall_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             flush_mux_o
);

    assign stall_o = idex_memread_i && (idex_rt_i != '0) &&
                     ((idex_rt_i == id_rs_i) || (idex_rt_i == id_rt_i));

    assign pc_write_o   = !stall_o;
    assign ifid_write_o = !stall_o;
    assign flush_mux_o  = stall_o;

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipeline control for the decoder's control bundles.
// Carries wb/ex/mem bundles through ID/EX, EX/MEM and MEM/WB, unpacks
// them per stage, detects load-use hazards, flushes IF/ID on taken
// branch or jump, produces EX forwarding selects and counts stall cycles.
// Ports:
//   clk_i, rst_i (async, active-low)
//   wb_i/ex_i/mem_i, jump_i, branch_i, eq_i, id_rs_i/id_rt_i/id_rd_i: ID inputs
//   pc_write_o, ifid_write_o, ifid_flush_o, flush_mux_o: front-end control
//   branch_taken_o, jump_o: PC source selects
//   ex_alusrc_o, ex_aluop_o, ex_regdst_o, fwd_a_o, fwd_b_o: EX stage
//   mem_read_o, mem_write_o: MEM stage
//   wb_regwrite_o, wb_memtoreg_o, wb_rd_o: WB stage
//   stall_cnt_o: saturating count of load-use stall cycles
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WB_W-1:0]  wb_i,
    input  logic [EX_W-1:0]  ex_i,
    input  logic [MEM_W-1:0] mem_i,
    input  logic             jump_i,
    input  logic             branch_i,
    input  logic             eq_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic [REG_W-1:0] id_rd_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             flush_mux_o,
    output logic             branch_taken_o,
    output logic             jump_o,
    output logic             ex_alusrc_o,
    output logic [1:0]       ex_aluop_o,
    output logic             ex_regdst_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             wb_regwrite_o,
    output logic             wb_memtoreg_o,
    output logic [REG_W-1:0] wb_rd_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    ctrl_t            idex_ctrl_q, idex_ctrl_d;
    logic [REG_W-1:0] idex_rs_q, idex_rt_q, idex_rd_q;
    logic [WB_W-1:0]  exmem_wb_q;
    logic [MEM_W-1:0] exmem_mem_q;
    logic [REG_W-1:0] exmem_dst_q, ex_dst;
    logic [WB_W-1:0]  memwb_wb_q;
    logic [REG_W-1:0] memwb_dst_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall;
    aluop_e           ex_aluop;
    fwd_e             fwd_a, fwd_b;

    hazard_detect u_hazard (
        .idex_memread_i (idex_ctrl_q.mem[MEM_READ]),
        .idex_rt_i      (idex_rt_q),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .stall_o        (stall),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .flush_mux_o    (flush_mux_o)
    );

    // Branch/jump bundles are scrubbed as well as stall bubbles, so decoder
    // don't-care bits on control-transfer instructions never reach EX.
    always_comb begin
        idex_ctrl_d = ctrl_t'{wb: wb_i, ex: ex_i, mem: mem_i};
        if (stall || branch_i || jump_i) begin
            idex_ctrl_d = BUBBLE;
        end
    end

    assign ex_dst = idex_ctrl_q.ex[EX_REGDST] ? idex_rt_q : idex_rd_q;

    assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1
                                                         : stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idex_ctrl_q <= BUBBLE;
            idex_rs_q   <= '0;
            idex_rt_q   <= '0;
            idex_rd_q   <= '0;
            exmem_wb_q  <= '0;
            exmem_mem_q <= '0;
            exmem_dst_q <= '0;
            memwb_wb_q  <= '0;
            memwb_dst_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            idex_ctrl_q <= idex_ctrl_d;
            idex_rs_q   <= id_rs_i;
            idex_rt_q   <= id_rt_i;
            idex_rd_q   <= id_rd_i;
            exmem_wb_q  <= idex_ctrl_q.wb;
            exmem_mem_q <= idex_ctrl_q.mem;
            exmem_dst_q <= ex_dst;
            memwb_wb_q  <= exmem_wb_q;
            memwb_dst_q <= exmem_dst_q;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // A stalled transfer is not lost: the ID instruction is held and
    // re-evaluated on the next cycle.
    assign branch_taken_o = !stall && branch_i && eq_i;
    assign jump_o         = !stall && jump_i;
    assign ifid_flush_o   = branch_taken_o || jump_o;

    assign ex_aluop    = aluop_e'(idex_ctrl_q.ex[EX_ALUOP_HI:EX_ALUOP_LO]);
    assign ex_alusrc_o = idex_ctrl_q.ex[EX_ALUSRC];
    assign ex_aluop_o  = ex_aluop;
    assign ex_regdst_o = idex_ctrl_q.ex[EX_REGDST];

    assign fwd_a = fwd_sel(exmem_wb_q[WB_REGWRITE], exmem_dst_q,
                           memwb_wb_q[WB_REGWRITE], memwb_dst_q, idex_rs_q);
    assign fwd_b = fwd_sel(exmem_wb_q[WB_REGWRITE], exmem_dst_q,
                           memwb_wb_q[WB_REGWRITE], memwb_dst_q, idex_rt_q);
    assign fwd_a_o = fwd_a;
    assign fwd_b_o = fwd_b;

    assign mem_read_o    = exmem_mem_q[MEM_READ];
    assign mem_write_o   = exmem_mem_q[MEM_WRITE];
    assign wb_regwrite_o = memwb_wb_q[WB_REGWRITE];
    assign wb_memtoreg_o = memwb_wb_q[WB_MEMTOREG];
    assign wb_rd_o       = memwb_dst_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumer end of the main decoder's control bundles: wb (RegWrite, MemtoReg), ex (ALUSrc, ALUOp, RegDst), mem (MemRead, MemWrite), plus jump and branch.
- Carries the bundles through the ID/EX, EX/MEM and MEM/WB control registers and unpacks them per stage.
- Generates load-use stall/bubble, IF/ID flush on taken branch or jump, and EX forwarding selects.
- Counts stall cycles for performance monitoring.

Parameters:
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
wb_i  in  2  {RegWrite, MemtoReg} from decoder
ex_i  in  4  {ALUSrc, ALUOp[1:0], RegDst} from decoder
mem_i  in  2  {MemRead, MemWrite} from decoder
jump_i  in  1  decoder jump control
branch_i  in  1  decoder branch control
eq_i  in  1  ID-stage register-equality compare result
id_rs_i  in  5  rs field of instruction in ID
id_rt_i  in  5  rt field of instruction in ID
id_rd_i  in  5  rd field of instruction in ID
pc_write_o  out  1  PC update enable
ifid_write_o  out  1  IF/ID register load enable
ifid_flush_o  out  1  clear IF/ID to nop next edge
flush_mux_o  out  1  bubble select: 1 = zero control into ID/EX
branch_taken_o  out  1  select branch target for PC
jump_o  out  1  select jump target for PC
ex_alusrc_o  out  1  1 = register operand B, 0 = immediate
ex_aluop_o  out  2  to ALU control: 00 add, 01 sub, 10 funct
ex_regdst_o  out  1  1 = rt destination, 0 = rd
fwd_a_o  out  2  operand A source: 00 regfile, 10 EX/MEM, 01 MEM/WB
fwd_b_o  out  2  operand B source, same encoding
mem_read_o  out  1  MEM-stage read enable
mem_write_o  out  1  MEM-stage write enable
wb_regwrite_o  out  1  WB-stage register write enable
wb_memtoreg_o  out  1  1 = memory data, 0 = ALU result
wb_rd_o  out  5  WB-stage destination register
stall_cnt_o  out  CNT_W  total load-use stall cycles, saturating

Behaviour:
- Reset (rst_i=0, asynchronous):
  - All pipeline registers (control, rs/rt/rd, destinations) and stall_cnt_o clear to 0.
  - Resulting outputs: pc_write_o=1, ifid_write_o=1; every other output 0.
- Register chain:
  - ID/EX holds {wb, ex, mem, rs, rt, rd}.
  - EX/MEM holds {wb, mem, dst}, where dst = RegDst ? rt : rd, resolved in EX.
  - MEM/WB holds {wb, dst}.
  - EX/MEM and MEM/WB load every cycle; they are never stalled.
- Stall (combinational), asserted when ID/EX MemRead=1, ID/EX rt != 0, and ID/EX rt equals id_rs_i or id_rt_i:
  - pc_write_o=0, ifid_write_o=0, flush_mux_o=1.
  - ID/EX control loads all-zero (bubble). Register fields load normally.
  - Exactly one bubble per lw→dependent pair.
- Scrub: when branch_i=1 or jump_i=1, ID/EX control loads zero, so decoder don't-care bits never propagate.
- Control transfer (only when no stall this cycle):
  - branch_i & eq_i: branch_taken_o=1, ifid_flush_o=1.
  - jump_i: jump_o=1, ifid_flush_o=1.
  - Stall coinciding with branch/jump: stall wins, both transfer outputs stay 0, and the transfer is re-evaluated next cycle with the same ID instruction.
- Forwarding, computed from registered state:
  - fwd_a_o = 10 if EX/MEM RegWrite, dst != 0 and dst == ID/EX rs.
  - Otherwise 01 if MEM/WB RegWrite, dst != 0 and dst == ID/EX rs.
  - Otherwise 00. EX/MEM takes priority.
  - fwd_b_o is identical using ID/EX rt.
- Destination register 0 never forwards and never triggers a stall.
- Latency: decoder bundle at ID edge n → ex_* valid cycle n+1, mem_* n+2, wb_* n+3.
- stall_cnt_o increments on each edge where the stall is asserted; it holds at all-ones (no wrap).
- Reset mid-stall: state clears; first cycle after release shows no stall.

Decomposition:
- Shared package ctrl_pkg:
  - Bundle widths, and bit indices within wb/ex/mem.
  - ALUOp codes: ADD=00, SUB=01, FUNCT=10.
  - FWD codes: REG=00, MEMWB=01, EXMEM=10.
  - BUBBLE constant: all-zero bundle.
- One sub-module, hazard_detect: load-use compare, producing stall, pc_write_o, ifid_write_o and flush_mux_o.

Test Plan:
- Reset release, ID fed add r3,r1,r2 (wb=10, ex=1100, mem=00) → cycle+1 ex_aluop_o=10, ex_regdst_o=0; cycle+3 wb_regwrite_o=1, wb_rd_o=3.
- lw r4 (ex=0001, mem=10, wb=11), then add r5,r4,r1 in ID → one cycle of pc_write_o=0, ifid_write_o=0, flush_mux_o=1; stall_cnt_o 0→1; add proceeds next cycle with fwd_a_o=01.
- add r3,... then sub r6,r3,r3 back-to-back → fwd_a_o=10, fwd_b_o=10; with one instruction between them → 01/01; any write to r0 → 00.
- beq with eq_i=1 → branch_taken_o=1, ifid_flush_o=1 for one cycle; next-cycle ex_* all 0. With eq_i=0 → both 0.
- Stall coinciding with jump_i=1 → jump_o=0 during the stall cycle, jump_o=1 on the following cycle.
- CNT_W=2, four stall cycles → stall_cnt_o reads 1, 2, 3, 3. Assert rst_i low mid-pipe → all outputs return to reset values without waiting for a clock edge.
